// File: rtl/axis_packet_arbiter.sv
// Round-robin arbiter merging NUM_SOURCES streams onto one registered output stream.
// Define AXIS_ARB_PKT_LOCK_EN to hold a grant from first beat through last; otherwise grants are per beat.
module axis_packet_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int SRC_W       = ($clog2(NUM_SOURCES) > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_SOURCES-1:0]            s_valid,
    input  logic [NUM_SOURCES-1:0]            s_start,
    input  logic [NUM_SOURCES-1:0]            s_last,
    output logic [NUM_SOURCES-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic                              m_valid,
    output logic                              m_start,
    output logic                              m_last,
    input  logic                              m_ready,
    output logic [SRC_W-1:0]                  grant_id,
    output logic                              busy
);

    // Handshake: a beat moves on a port when valid and ready are both high at the rising edge;
    // ready may depend on valid, but valid never depends on ready.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]      owner_q, owner_d;
    logic [SRC_W-1:0]      grant_id_q, grant_id_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_start_q, m_start_d;
    logic                  m_last_q, m_last_d;

    logic [SRC_W-1:0]      rr_sel;
    logic [SRC_W-1:0]      sel;
    logic [SRC_W-1:0]      sel_inc;
    logic                  out_free;
    logic                  accept;
    int                    idx;

    // Scan downward so the lowest offset from rr_ptr_q wins.
    always_comb begin
        rr_sel = rr_ptr_q;
        idx    = 0;
        for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_SOURCES) begin
                idx = idx - NUM_SOURCES;
            end
            if (s_valid[idx]) begin
                rr_sel = SRC_W'(idx);
            end
        end
    end

    assign sel      = (state_q == LOCKED) ? owner_q : rr_sel;
    assign sel_inc  = (int'(sel) == NUM_SOURCES - 1) ? '0 : sel + SRC_W'(1);
    assign out_free = !m_valid_q || m_ready;

    always_comb begin
        s_ready = '0;
        if (rst_n && out_free && ((state_q == LOCKED) || s_valid[sel])) begin
            s_ready[sel] = 1'b1;
        end
    end

    assign accept = s_valid[sel] && s_ready[sel];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        grant_id_d = grant_id_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_start_d  = m_start_q;
        m_last_d   = m_last_q;
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (accept) begin
            m_data_d   = s_data[sel*DATA_WIDTH +: DATA_WIDTH];
            m_start_d  = s_start[sel];
            m_last_d   = s_last[sel];
            m_valid_d  = 1'b1;
            grant_id_d = sel;
`ifdef AXIS_ARB_PKT_LOCK_EN
            if (s_last[sel]) begin
                state_d  = IDLE;
                rr_ptr_d = sel_inc;
            end else if (state_q == IDLE) begin
                state_d = LOCKED;
                owner_d = sel;
            end
`else
            rr_ptr_d = sel_inc;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            grant_id_q <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_start_q  <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            grant_id_q <= grant_id_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_start_q  <= m_start_d;
            m_last_q   <= m_last_d;
        end
    end

    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign m_start  = m_start_q;
    assign m_last   = m_last_q;
    assign grant_id = grant_id_q;

`ifdef AXIS_ARB_PKT_LOCK_EN
    assign busy = (state_q == LOCKED);
`else
    assign busy = 1'b0;
`endif

endmodule
